// File: rtl/sd_emmc_oddr_tx.sv
// rtl/sd_emmc_oddr_tx.sv - eMMC DDR52 8-bit write-data framer feeding an ODDR cell (q1 rising, q2 falling).
// Optional macro SD_EMMC_ODDR_CRC_ERR_INJ_EN adds i_crc_err_inj to corrupt the last rising CRC bit of DAT0.
module sd_emmc_oddr_tx #(
  parameter int         BLK_WORDS_W = 9,
  parameter logic [7:0] IDLE_LEVEL  = 8'hFF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [BLK_WORDS_W-1:0] i_blk_words,
`ifdef SD_EMMC_ODDR_CRC_ERR_INJ_EN
  input  logic                   i_crc_err_inj,
`endif
  input  logic [15:0]            i_data_in,
  input  logic                   i_data_valid,
  output logic                   o_data_ready,
  output logic [7:0]             o_dat_q1,
  output logic [7:0]             o_dat_q2,
  output logic                   o_dat_oe,
  output logic                   o_clk_stall,
  output logic                   o_busy,
  output logic                   o_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_CRC   = 3'd4,
    S_END   = 3'd5
  } state_t;

  localparam logic [BLK_WORDS_W-1:0] REM_ONE  = BLK_WORDS_W'(1);
  localparam logic [BLK_WORDS_W-1:0] REM_ZERO = '0;

  state_t                 r_state;
  logic [BLK_WORDS_W-1:0] r_rem;
  logic [3:0]             r_k;
  logic [7:0]             r_q1;
  logic [7:0]             r_q2;
  logic                   r_oe;
  logic                   r_busy;
  logic                   r_done;
  logic [15:0]            r_crc_r [8];
  logic [15:0]            r_crc_f [8];
  logic [15:0]            w_crc_r_nxt [8];
  logic [15:0]            w_crc_f_nxt [8];
  logic [7:0]             w_msb_r;
  logic [7:0]             w_msb_f;
  logic                   w_data_ready;
  logic                   w_accept;
  logic                   w_flip;

  // Serial CRC16-CCITT step, one DAT bit per emitted word.
  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    crc16_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  assign w_data_ready = (r_state == S_START) || ((r_state == S_DATA) && (r_rem > REM_ONE));
  assign w_accept     = w_data_ready && i_data_valid;
  assign o_data_ready = w_data_ready;
  assign o_clk_stall  = w_data_ready && !i_data_valid;
  assign o_dat_q1     = r_q1;
  assign o_dat_q2     = r_q2;
  assign o_dat_oe     = r_oe;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

  always_comb begin
    w_msb_r = 8'h00;
    w_msb_f = 8'h00;
    for (int i = 0; i < 8; i++) begin
      w_crc_r_nxt[i] = crc16_step(r_crc_r[i], i_data_in[i]);
      w_crc_f_nxt[i] = crc16_step(r_crc_f[i], i_data_in[8+i]);
      w_msb_r[i]     = r_crc_r[i][15];
      w_msb_f[i]     = r_crc_f[i][15];
    end
  end

`ifdef SD_EMMC_ODDR_CRC_ERR_INJ_EN
  logic r_inj;
  // r_k==14 in CRC means the bit about to be emitted is k=15 (shift register leads the counter).
  assign w_flip = r_inj && (r_state == S_CRC) && (r_k == 4'd14);
`else
  assign w_flip = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_rem   <= REM_ZERO;
      r_k     <= 4'd0;
      r_q1    <= IDLE_LEVEL;
      r_q2    <= IDLE_LEVEL;
      r_oe    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_crc_r[i] <= 16'h0000;
        r_crc_f[i] <= 16'h0000;
      end
`ifdef SD_EMMC_ODDR_CRC_ERR_INJ_EN
      r_inj   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (i_abort) begin
        r_state <= S_IDLE;
        r_q1    <= IDLE_LEVEL;
        r_q2    <= IDLE_LEVEL;
        r_oe    <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start && (i_blk_words != REM_ZERO)) begin
              r_state <= S_PRE;
              r_rem   <= i_blk_words;
              r_k     <= 4'd0;
              r_q1    <= 8'hFF;
              r_q2    <= 8'hFF;
              r_oe    <= 1'b1;
              r_busy  <= 1'b1;
              for (int i = 0; i < 8; i++) begin
                r_crc_r[i] <= 16'h0000;
                r_crc_f[i] <= 16'h0000;
              end
`ifdef SD_EMMC_ODDR_CRC_ERR_INJ_EN
              r_inj   <= i_crc_err_inj;
`endif
            end
          end
          S_PRE: begin
            r_state <= S_START;
            r_q1    <= 8'h00;
            r_q2    <= 8'h00;
          end
          S_START: begin
            if (w_accept) begin
              r_state <= S_DATA;
              r_q1    <= i_data_in[7:0];
              r_q2    <= i_data_in[15:8];
              for (int i = 0; i < 8; i++) begin
                r_crc_r[i] <= w_crc_r_nxt[i];
                r_crc_f[i] <= w_crc_f_nxt[i];
              end
            end
          end
          S_DATA: begin
            if (r_rem == REM_ONE) begin
              // Last word already folded into the CRCs at its accept edge; start shifting them out.
              r_state <= S_CRC;
              r_k     <= 4'd0;
              r_q1    <= w_msb_r;
              r_q2    <= w_msb_f;
              for (int i = 0; i < 8; i++) begin
                r_crc_r[i] <= {r_crc_r[i][14:0], 1'b0};
                r_crc_f[i] <= {r_crc_f[i][14:0], 1'b0};
              end
            end else if (w_accept) begin
              r_rem <= r_rem - REM_ONE;
              r_q1  <= i_data_in[7:0];
              r_q2  <= i_data_in[15:8];
              for (int i = 0; i < 8; i++) begin
                r_crc_r[i] <= w_crc_r_nxt[i];
                r_crc_f[i] <= w_crc_f_nxt[i];
              end
            end
          end
          S_CRC: begin
            if (r_k == 4'd15) begin
              r_state <= S_END;
              r_q1    <= 8'hFF;
              r_q2    <= 8'hFF;
            end else begin
              r_k  <= r_k + 4'd1;
              r_q1 <= w_msb_r ^ {7'b0, w_flip};
              r_q2 <= w_msb_f;
              for (int i = 0; i < 8; i++) begin
                r_crc_r[i] <= {r_crc_r[i][14:0], 1'b0};
                r_crc_f[i] <= {r_crc_f[i][14:0], 1'b0};
              end
            end
          end
          S_END: begin
            r_state <= S_IDLE;
            r_q1    <= IDLE_LEVEL;
            r_q2    <= IDLE_LEVEL;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
          default: begin
            r_state <= S_IDLE;
            r_q1    <= IDLE_LEVEL;
            r_q2    <= IDLE_LEVEL;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
